// File: rtl/conf_port_arbiter_if.sv
// conf_port_arbiter_if
//   Bundles the requester handshakes and the memory configuration bus that
//   the arbiter sits between.
//   Requester side (x = 0 network config path, x = 1 local debug/host path):
//     reqx_valid/we/lock/addr/wdata  request from requester x
//     reqx_ready                     request accepted this cycle
//     rspx_valid/rdata               read response, one-cycle pulse
//   Memory side:
//     conf_rden/wren/addr/wdata      registered strobes towards the memory
//     conf_rdata                     read data returned by the memory
//   Modports: slave = arbiter view, master = requester/memory environment view.
interface conf_port_arbiter_if;
    logic        req0_valid;
    logic        req0_we;
    logic        req0_lock;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;

    logic        req1_valid;
    logic        req1_we;
    logic        req1_lock;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;

    logic        conf_rden;
    logic        conf_wren;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output conf_rden, conf_wren, conf_addr, conf_wdata,
        input  conf_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  conf_rden, conf_wren, conf_addr, conf_wdata,
        output conf_rdata
    );
endinterface

// File: rtl/conf_port_arbiter.sv
// conf_port_arbiter
//   Shares the single ITCM/DTCM configuration port between the network
//   configuration path (requester 0) and the local debug/host path
//   (requester 1). One transaction is granted per cycle, round-robin, with
//   an optional lock that lets one requester stream a burst of up to
//   MAX_BURST transactions while the other waits. Reads are tagged with the
//   issuing requester and their data is routed back RD_LAT + 2 cycles after
//   the accept.
//   Ports:
//     clk, resetn   clock, asynchronous active-low reset
//     cfg_enable    1 = grants allowed, 0 = stall all grants
//     busy          read response outstanding or owner lock held
//     bus           requester handshakes and memory config bus (slave view)
module conf_port_arbiter #(
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_enable,
    output logic              busy,
    conf_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_0    = 2'd1,
        OWNER_1    = 2'd2
    } owner_e;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    logic [1:0]  reqValid;
    logic [1:0]  reqWe;
    logic [1:0]  reqLock;
    logic [31:0] reqAddr  [2];
    logic [31:0] reqWdata [2];

    owner_e      owner_q,    owner_d;
    logic [7:0]  burstCnt_q, burstCnt_d;
    logic        rrLast_q,   rrLast_d;

    logic [1:0]  lockHold;
    logic [1:0]  grant;
    logic        grantId;
    logic        accept;

    logic        confRden_q;
    logic        confWren_q;
    logic [31:0] confAddr_q;
    logic [31:0] confWdata_q;
    logic        issueId_q;

    logic [RD_LAT-1:0] tagValid_q;
    logic [RD_LAT-1:0] tagId_q;

    logic [1:0]  rspValid_q;
    logic [31:0] rspRdata0_q;
    logic [31:0] rspRdata1_q;

    assign reqValid    = {bus.req1_valid, bus.req0_valid};
    assign reqWe       = {bus.req1_we,    bus.req0_we};
    assign reqLock     = {bus.req1_lock,  bus.req0_lock};
    assign reqAddr[0]  = bus.req0_addr;
    assign reqAddr[1]  = bus.req1_addr;
    assign reqWdata[0] = bus.req0_wdata;
    assign reqWdata[1] = bus.req1_wdata;

    // A locked owner keeps the port while it still asks for it, unless the
    // other side is waiting and the burst allowance is used up.
    always_comb begin
        lockHold    = 2'b00;
        lockHold[0] = (owner_q == OWNER_0) && reqValid[0] && reqLock[0] &&
                      (!reqValid[1] || (burstCnt_q < BURST_LIMIT));
        lockHold[1] = (owner_q == OWNER_1) && reqValid[1] && reqLock[1] &&
                      (!reqValid[0] || (burstCnt_q < BURST_LIMIT));
    end

    // Grant selection. When the lock cannot be honoured the round-robin
    // pointer already names the owner as last winner, so the waiting
    // requester is picked, which is what forces the rotation.
    always_comb begin
        grant = 2'b00;
        if (cfg_enable) begin
            if (lockHold[0]) begin
                grant = 2'b01;
            end else if (lockHold[1]) begin
                grant = 2'b10;
            end else if (reqValid == 2'b11) begin
                grant = rrLast_q ? 2'b01 : 2'b10;
            end else begin
                grant = reqValid;
            end
        end
    end

    assign accept  = |grant;
    assign grantId = grant[1];

    // Owner, burst counter and round-robin pointer next state.
    always_comb begin
        owner_e grantOwner;
        owner_d    = owner_q;
        burstCnt_d = burstCnt_q;
        rrLast_d   = rrLast_q;
        grantOwner = grantId ? OWNER_1 : OWNER_0;
        if (accept) begin
            rrLast_d = grantId;
            if (reqLock[grantId]) begin
                owner_d = grantOwner;
                if (owner_q == grantOwner) begin
                    burstCnt_d = (burstCnt_q == 8'hFF) ? 8'hFF : burstCnt_q + 8'd1;
                end else begin
                    burstCnt_d = 8'd1;
                end
            end else begin
                owner_d    = OWNER_NONE;
                burstCnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q    <= OWNER_NONE;
            burstCnt_q <= 8'd0;
            rrLast_q   <= 1'b1;
        end else begin
            owner_q    <= owner_d;
            burstCnt_q <= burstCnt_d;
            rrLast_q   <= rrLast_d;
        end
    end

    // Issue stage: the accepted request is presented to the memory one
    // cycle later; address and data hold their last value between strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            confRden_q  <= 1'b0;
            confWren_q  <= 1'b0;
            confAddr_q  <= 32'd0;
            confWdata_q <= 32'd0;
            issueId_q   <= 1'b0;
        end else begin
            confRden_q <= accept && !reqWe[grantId];
            confWren_q <= accept &&  reqWe[grantId];
            if (accept) begin
                confAddr_q  <= reqAddr[grantId];
                confWdata_q <= reqWdata[grantId];
                issueId_q   <= grantId;
            end
        end
    end

    // Read tag pipeline: stage 0 is loaded while conf_rden is high, so the
    // last stage lines up with the cycle conf_rdata is valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tagValid_q <= '0;
            tagId_q    <= '0;
        end else begin
            tagValid_q[0] <= confRden_q;
            tagId_q[0]    <= issueId_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tagValid_q[k] <= tagValid_q[k-1];
                tagId_q[k]    <= tagId_q[k-1];
            end
        end
    end

    // Response capture: data is held until the next response to the same
    // requester, the valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rspValid_q  <= 2'b00;
            rspRdata0_q <= 32'd0;
            rspRdata1_q <= 32'd0;
        end else begin
            rspValid_q <= 2'b00;
            if (tagValid_q[RD_LAT-1]) begin
                if (tagId_q[RD_LAT-1]) begin
                    rspValid_q[1] <= 1'b1;
                    rspRdata1_q   <= bus.conf_rdata;
                end else begin
                    rspValid_q[0] <= 1'b1;
                    rspRdata0_q   <= bus.conf_rdata;
                end
            end
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.rsp0_valid = rspValid_q[0];
    assign bus.rsp1_valid = rspValid_q[1];
    assign bus.rsp0_rdata = rspRdata0_q;
    assign bus.rsp1_rdata = rspRdata1_q;
    assign bus.conf_rden  = confRden_q;
    assign bus.conf_wren  = confWren_q;
    assign bus.conf_addr  = confAddr_q;
    assign bus.conf_wdata = confWdata_q;

    assign busy = (|tagValid_q) || (owner_q != OWNER_NONE);

endmodule

// File: tb/tb_conf_port_arbiter.sv
// tb_conf_port_arbiter
//   Drives conf_port_arbiter with a table of directed vectors, a few
//   hand-written multi-cycle sequences and random traffic. A reference
//   model (grant rules, a word memory and a queue of expected read
//   responses) predicts every output; a small memory model answers the
//   configuration bus with RD_LAT cycles of read latency.
module tb_conf_port_arbiter;

    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic        en;
        logic        v0, we0, lk0;
        logic [31:0] a0, d0;
        logic        v1, we1, lk1;
        logic [31:0] a1, d1;
        logic        expR0, expR1;
    } vec_t;

    typedef struct {
        logic        r0, r1, wren, rden, rsp0v, rsp1v;
        logic [31:0] addr, wdata, rsp0d, rsp1d;
    } obs_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

    logic clk;
    logic resetn;
    logic cfgEnable;
    logic busy;

    conf_port_arbiter_if bus();

    conf_port_arbiter #(
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_enable (cfgEnable),
        .busy       (busy),
        .bus        (bus)
    );

    int vectorCount = 0;
    int missCount   = 0;
    int cycleNum    = 0;

    // Reference model state
    int          mOwner;
    int          mCnt;
    int          mRr;
    logic [31:0] mMem [int];
    rsp_t        rspQ [$];
    issue_t      expIssue;

    // Memory model state
    logic [31:0] tbMem [int];
    logic [31:0] rdPipe [RD_LAT];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] initPattern(input logic [31:0] a);
        return 32'hC0DE_0000 | {24'd0, a[7:0]};
    endfunction

    function automatic logic [31:0] tbMemRead(input logic [31:0] a);
        return tbMem.exists(int'(a[7:0])) ? tbMem[int'(a[7:0])] : initPattern(a);
    endfunction

    function automatic logic [31:0] modelMemRead(input logic [31:0] a);
        return mMem.exists(int'(a[7:0])) ? mMem[int'(a[7:0])] : initPattern(a);
    endfunction

    // Memory answering the configuration bus, RD_LAT cycles after conf_rden
    always @(posedge clk) begin
        for (int k = RD_LAT - 1; k > 0; k--) rdPipe[k] <= rdPipe[k-1];
        rdPipe[0] <= bus.conf_rden ? tbMemRead(bus.conf_addr) : 32'hBAD0_BAD0;
        if (bus.conf_wren) tbMem[int'(bus.conf_addr[7:0])] = bus.conf_wdata;
    end
    assign bus.conf_rdata = rdPipe[RD_LAT-1];

    function automatic vec_t mkVec(
        input logic en,
        input logic v0, input logic we0, input logic lk0,
        input logic [31:0] a0, input logic [31:0] d0,
        input logic v1, input logic we1, input logic lk1,
        input logic [31:0] a1, input logic [31:0] d1,
        input logic r0, input logic r1);
        vec_t v;
        v.en = en;
        v.v0 = v0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
        v.expR0 = r0; v.expR1 = r1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h",
                     name, cycleNum, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cfgEnable      = v.en;
        bus.req0_valid = v.v0;
        bus.req0_we    = v.we0;
        bus.req0_lock  = v.lk0;
        bus.req0_addr  = v.a0;
        bus.req0_wdata = v.d0;
        bus.req1_valid = v.v1;
        bus.req1_we    = v.we1;
        bus.req1_lock  = v.lk1;
        bus.req1_addr  = v.a1;
        bus.req1_wdata = v.d1;
    endtask

    task automatic applyIdle();
        applyStimulus(mkVec(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    endtask

    // Which requester the arbitration rules pick this cycle, -1 for none
    function automatic int modelGrant();
        logic [1:0] v;
        logic [1:0] lk;
        v  = {bus.req1_valid, bus.req0_valid};
        lk = {bus.req1_lock,  bus.req0_lock};
        if (!cfgEnable) return -1;
        for (int i = 0; i < 2; i++) begin
            if (mOwner == i && v[i] && lk[i] && (!v[1-i] || mCnt < MAX_BURST))
                return i;
        end
        if (v == 2'b11) return 1 - mRr;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    function automatic void modelReset();
        mOwner = -1;
        mCnt   = 0;
        mRr    = 1;
        rspQ.delete();
        expIssue = '{valid: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0};
    endfunction

    // One clock cycle: sample and check at the falling edge, advance the
    // model, then return 1 time unit after the next rising edge.
    task automatic stepCycle(output obs_t o);
        int          g;
        logic        expBusy;
        logic        rspDue;
        rsp_t        r;
        logic        we, lk;
        logic [31:0] a, d;

        @(negedge clk);
        o.r0    = bus.req0_ready;   o.r1    = bus.req1_ready;
        o.wren  = bus.conf_wren;    o.rden  = bus.conf_rden;
        o.addr  = bus.conf_addr;    o.wdata = bus.conf_wdata;
        o.rsp0v = bus.rsp0_valid;   o.rsp1v = bus.rsp1_valid;
        o.rsp0d = bus.rsp0_rdata;   o.rsp1d = bus.rsp1_rdata;

        g = modelGrant();
        checkOutput("req0_ready", o.r0, 32'(g == 0));
        checkOutput("req1_ready", o.r1, 32'(g == 1));

        checkOutput("conf_wren", o.wren, 32'(expIssue.valid &&  expIssue.we));
        checkOutput("conf_rden", o.rden, 32'(expIssue.valid && !expIssue.we));
        if (expIssue.valid) begin
            checkOutput("conf_addr", o.addr, expIssue.addr);
            if (expIssue.we) checkOutput("conf_wdata", o.wdata, expIssue.wdata);
        end

        rspDue = 1'b0;
        r = '{due: 0, id: 0, data: 32'd0};
        if (rspQ.size() > 0 && rspQ[0].due == cycleNum) begin
            r = rspQ.pop_front();
            rspDue = 1'b1;
        end
        checkOutput("rsp0_valid", o.rsp0v, 32'(rspDue && r.id == 0));
        checkOutput("rsp1_valid", o.rsp1v, 32'(rspDue && r.id == 1));
        if (rspDue && r.id == 0) checkOutput("rsp0_rdata", o.rsp0d, r.data);
        if (rspDue && r.id == 1) checkOutput("rsp1_rdata", o.rsp1d, r.data);

        expBusy = (mOwner >= 0);
        foreach (rspQ[k]) begin
            if (rspQ[k].due - RD_LAT <= cycleNum && cycleNum < rspQ[k].due) expBusy = 1'b1;
        end
        checkOutput("busy", busy, 32'(expBusy));

        expIssue.valid = 1'b0;
        if (g >= 0) begin
            we = (g == 1) ? bus.req1_we    : bus.req0_we;
            lk = (g == 1) ? bus.req1_lock  : bus.req0_lock;
            a  = (g == 1) ? bus.req1_addr  : bus.req0_addr;
            d  = (g == 1) ? bus.req1_wdata : bus.req0_wdata;
            expIssue = '{valid: 1'b1, we: we, addr: a, wdata: d};
            if (we) mMem[int'(a[7:0])] = d;
            else    rspQ.push_back('{due: cycleNum + RD_LAT + 2, id: g, data: modelMemRead(a)});
            if (lk) begin
                mCnt   = (mOwner == g) ? ((mCnt < 255) ? mCnt + 1 : 255) : 1;
                mOwner = g;
            end else begin
                mOwner = -1;
                mCnt   = 0;
            end
            mRr = g;
        end

        @(posedge clk);
        #1;
        cycleNum++;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic doReset();
        applyStimulus(mkVec(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
        resetn = 1'b0;
        #2;
        checkOutput("reset conf_rden",  bus.conf_rden,  32'd0);
        checkOutput("reset conf_wren",  bus.conf_wren,  32'd0);
        checkOutput("reset conf_addr",  bus.conf_addr,  32'd0);
        checkOutput("reset conf_wdata", bus.conf_wdata, 32'd0);
        checkOutput("reset rsp0_valid", bus.rsp0_valid, 32'd0);
        checkOutput("reset rsp1_valid", bus.rsp1_valid, 32'd0);
        checkOutput("reset rsp0_rdata", bus.rsp0_rdata, 32'd0);
        checkOutput("reset rsp1_rdata", bus.rsp1_rdata, 32'd0);
        checkOutput("reset busy",       busy,           32'd0);
        checkOutput("reset req0_ready", bus.req0_ready, 32'd0);
        checkOutput("reset req1_ready", bus.req1_ready, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycleNum++;
        modelReset();
    endtask

    vec_t tbl [$];
    obs_t o;

    initial begin
        resetn = 1'b1;
        applyIdle();
        modelReset();
        #1;
        doReset();

        // Write 0x10 from requester 0: accepted at once, one-cycle strobe next
        applyStimulus(mkVec(1, 1,1,0,32'h10,32'hDEADBEEF, 0,0,0,0,0, 1,0));
        stepCycle(o);
        checkOutput("t1 req0_ready", o.r0, 32'd1);
        applyIdle();
        stepCycle(o);
        checkOutput("t1 conf_wren",  o.wren,  32'd1);
        checkOutput("t1 conf_addr",  o.addr,  32'h10);
        checkOutput("t1 conf_wdata", o.wdata, 32'hDEADBEEF);
        stepCycle(o);
        checkOutput("t1 conf_wren off", o.wren, 32'd0);

        // Read 0x10 from requester 1: response 4 cycles after accept
        applyStimulus(mkVec(1, 0,0,0,0,0, 1,0,0,32'h10,0, 0,1));
        stepCycle(o);
        checkOutput("t2 req1_ready", o.r1, 32'd1);
        applyIdle();
        for (int k = 1; k <= 4; k++) begin
            stepCycle(o);
            checkOutput("t2 rsp1_valid", o.rsp1v, 32'(k == 4));
            checkOutput("t2 rsp0_valid", o.rsp0v, 32'd0);
        end
        checkOutput("t2 rsp1_rdata", o.rsp1d, 32'hDEADBEEF);

        // Alternating grants, locked burst with forced rotation, cfg stall
        for (int i = 0; i < 6; i++)
            tbl.push_back(mkVec(1, 1,1,0,32'h20 + 32'(4*i),32'h1111_0000 + 32'(i),
                                   1,0,0,32'h10,0, (i % 2) == 0, (i % 2) == 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkVec(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mkVec(1, 1,1,1,32'h40 + 32'(4*i),32'h2222_0000 + 32'(i),
                                   1,1,0,32'h80,32'h3333_0000, i != 4, i == 4));
        tbl.push_back(mkVec(1, 1,0,0,32'h40,0, 0,0,0,0,0, 1,0));
        tbl.push_back(mkVec(0, 1,1,0,32'h50,32'h44,  1,1,0,32'h54,32'h55, 0,0));
        tbl.push_back(mkVec(0, 1,1,0,32'h50,32'h44,  1,1,0,32'h54,32'h55, 0,0));
        tbl.push_back(mkVec(1, 1,1,0,32'h50,32'h44,  1,1,0,32'h54,32'h55, 0,1));
        tbl.push_back(mkVec(1, 1,1,0,32'h50,32'h44,  1,0,0,32'h40,32'h0,  1,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkVec(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            stepCycle(o);
            checkOutput("tbl req0_ready", o.r0, 32'(tbl[i].expR0));
            checkOutput("tbl req1_ready", o.r1, 32'(tbl[i].expR1));
        end

        // Reset while two reads are in flight: both responses are dropped
        applyStimulus(mkVec(1, 1,0,0,32'h20,0, 0,0,0,0,0, 1,0));
        stepCycle(o);
        applyStimulus(mkVec(1, 0,0,0,0,0, 1,0,0,32'h30,0, 0,1));
        stepCycle(o);
        applyIdle();
        stepCycle(o);
        doReset();
        for (int k = 0; k < 6; k++) begin
            stepCycle(o);
            checkOutput("t6 rsp0_valid", o.rsp0v, 32'd0);
            checkOutput("t6 rsp1_valid", o.rsp1v, 32'd0);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(mkVec($urandom_range(0, 9) != 0,
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)),
                                $urandom & 32'hFFFF_00FC, $urandom,
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                $urandom_range(0, 3) == 0,
                                $urandom & 32'hFFFF_00FC, $urandom,
                                0, 0));
            stepCycle(o);
        end
        applyIdle();
        for (int k = 0; k < RD_LAT + 4; k++) stepCycle(o);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/conf_port_arbiter.md
Name: conf_port_arbiter

Overview:
- Shares the single ITCM/DTCM configuration port between two requesters.
  - Requester 0: the network configuration path (packet-driven program load/readback).
  - Requester 1: the local debug/host path.
- Grants one transaction per cycle using round-robin, with optional burst locking for program loads.
- Routes read data back to the requester that issued the read.
- Sits between the requesters and the CPU memory configuration interface (conf_rden/conf_wren/conf_addr/conf_wdata/conf_rdata/conf_sel).

Parameters:
- RD_LAT, 2: cycles from conf_rden asserted to conf_rdata valid at this block; legal range 1..4.
- MAX_BURST, 64: maximum consecutive grants to a locked owner while the other requester waits; legal range 1..255.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cfg_enable  in  1  1 = configuration allowed (CPU in configure mode); 0 = stall all grants
- req0_valid  in  1  requester 0 transaction request
- req0_we  in  1  1 = write, 0 = read
- req0_lock  in  1  hold grant for following transactions (burst)
- req0_addr  in  32  address
- req0_wdata  in  32  write data
- req0_ready  out  1  transaction accepted this cycle (combinational)
- rsp0_valid  out  1  read response valid, one-cycle pulse
- rsp0_rdata  out  32  read response data
- req1_*/rsp1_*  same set as requester 0, for requester 1
- conf_rden  out  1  read strobe to memory
- conf_wren  out  1  write strobe to memory
- conf_addr  out  32  address to memory
- conf_wdata  out  32  write data to memory
- conf_rdata  in  32  read data, valid RD_LAT cycles after conf_rden
- busy  out  1  read response outstanding or owner lock held

Behaviour:
- Reset (asynchronous, resetn=0):
  - All outputs 0: conf_rden, conf_wren, conf_addr, conf_wdata, rsp*_valid, rsp*_rdata, busy.
  - owner = NONE, rr_last = 1 (so requester 0 wins first), burst_cnt = 0, read tag pipeline cleared.
  - Reset mid-read drops the outstanding response; no rsp pulse after reset release.
- Arbitration (combinational per cycle, only when cfg_enable=1):
  - If owner = i, reqi_valid=1, reqi_lock=1 and (other requester idle or burst_cnt < MAX_BURST): grant i.
  - Otherwise, among valid requesters: grant the one not equal to rr_last; grant the sole one if only one is valid.
  - reqi_ready = grant_i. At most one ready per cycle.
  - cfg_enable=0: both ready = 0, conf strobes 0 next cycle, owner and burst_cnt held.
- Lock and burst counter:
  - On accept by i with reqi_lock=1: owner <= i.
  - burst_cnt <= (owner already i) ? burst_cnt+1, saturating at 255 : 1.
  - On accept with lock=0, or on a forced rotation: owner <= NONE, burst_cnt <= 0.
  - Forced rotation: when burst_cnt = MAX_BURST and the other requester is valid, grant the other and set rr_last to it.
- Issue stage (registered, 1 cycle after accept):
  - conf_wren = we, conf_rden = ~we, conf_addr/conf_wdata from the accepted request.
  - Strobes deassert the following cycle unless a new accept occurs.
  - Back-to-back accepts produce continuous strobes.
- Read routing:
  - tag pipeline of RD_LAT stages, each {valid, id}, loaded at the conf_rden cycle.
  - At stage RD_LAT: capture conf_rdata into rsp<id>_rdata and pulse rsp<id>_valid the next cycle.
  - Total read latency accept -> rsp_valid = RD_LAT + 2 cycles.
  - Pipelined reads are allowed every cycle; responses return in issue order.
- Simultaneous events:
  - Both requesters valid with no lock: alternate grants.
  - Read response for one requester and new accept for the other in the same cycle are independent.
- busy = any tag valid OR owner != NONE.
- Write to an address being read in flight: no ordering hazard handling; order is issue order at the memory.

Test Plan:
1. Reset, then req0 write addr 0x10 data 0xDEADBEEF -> req0_ready same cycle; next cycle conf_wren=1, conf_addr=0x10, conf_wdata=0xDEADBEEF for exactly 1 cycle.
2. req1 read 0x10 with memory model RD_LAT=2 returning 0xDEADBEEF -> rsp1_valid pulse 4 cycles after accept with rsp1_rdata=0xDEADBEEF; rsp0_valid stays 0.
3. Both valid, no lock, 6 cycles -> grants 0,1,0,1,0,1; conf_addr alternates accordingly.
4. req0 lock=1 continuous, req1 valid, MAX_BURST=4 -> four req0 grants, then one req1 grant, then req0 resumes.
5. cfg_enable=0 while both valid -> no ready, no conf strobes; raise cfg_enable -> granting resumes from the held rr_last.
6. Reads issued back-to-back from 0 then 1, with resetn pulsed low 1 cycle after the second issue -> no rsp pulses after reset; all outputs 0.
